// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic multi-lane pipe: slice state
// encoding, occupancy counter sizing and the lane packing offset.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_e;

  // A DEPTH-stage pipe holds up to 2*DEPTH beats; the counter must reach that.
  function automatic int cnt_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  // Lane k of a packed bus lives at bits [lane_lsb(k, w) +: w].
  function automatic int lane_lsb(input int lane, input int d_width);
    return lane * d_width;
  endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// One registered-ready skid stage: a main register that drives the output
// and a skid register that absorbs the beat arriving while ready drops.
module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int W        = 8,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  slice_state_e state_q, state_d;
  logic         ready_q;
  logic         valid_q;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         drain;
  logic         clear;

  assign accept = in_valid && ready_q;
  assign drain  = valid_q && out_ready;
  assign clear  = !rst_n || flush;

  // NOTE: every output gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (accept && drain) begin
          main_d = in_data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together at the edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      valid_q <= (state_d != EMPTY);
    end
  end

  generate
    if (CLR_DATA) begin : g_clr_data
      always_ff @(posedge clk) begin
        if (clear) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          main_q <= main_d;
          skid_q <= skid_d;
        end
      end
    end else begin : g_hold_data
      // NOTE: wide data registers are intentionally not reset; the valid state alone says whether they hold a beat.
      always_ff @(posedge clk) begin
        if (!clear) begin
          main_q <= main_d;
          skid_q <= skid_d;
        end
      end
    end
  endgenerate

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/pipe_lanes_elastic.sv
// Parametrised multi-lane elastic pipe: DEPTH chained skid slices carrying
// all lanes as one beat, plus a registered occupancy counter.
module pipe_lanes_elastic
  import pipe_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int D_WIDTH  = 192,
  parameter int DEPTH    = 1,
  parameter bit CLR_DATA = 1'b1,
  parameter int CNT_W    = cnt_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*D_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*D_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]         occupancy
);

  localparam int W = LANES * D_WIDTH;

  logic [DEPTH:0] valid_c;
  logic [DEPTH:0] ready_c;
  logic [W-1:0]   data_c [DEPTH+1];

  assign valid_c[0]     = in_valid;
  assign data_c[0]      = in_data;
  assign in_ready       = ready_c[0];
  assign out_valid      = valid_c[DEPTH];
  assign out_data       = data_c[DEPTH];
  assign ready_c[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    pipe_skid_slice #(
      .W        (W),
      .CLR_DATA (CLR_DATA)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (valid_c[i]),
      .in_ready  (ready_c[i]),
      .in_data   (data_c[i]),
      .out_valid (valid_c[i+1]),
      .out_ready (ready_c[i+1]),
      .out_data  (data_c[i+1])
    );
  end

  // Only the pipe boundaries change the count; hand-offs between slices do not.
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_lanes_elastic.sv
// Directed bench for pipe_lanes_elastic: three instances cover the wide
// DEPTH=3 pipe, a narrow DEPTH=2 pipe and a DEPTH=1 pipe without data clear.
module tb_pipe_lanes_elastic;
  import pipe_pkg::*;

  localparam int W3  = 16 * 192;
  localparam int W2  = 4 * 16;
  localparam int W1  = 2 * 8;
  localparam int CW3 = cnt_width(3);
  localparam int CW2 = cnt_width(2);
  localparam int CW1 = cnt_width(1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst3, flush3, in_v3, in_rdy3, out_v3, out_r3;
  logic [W3-1:0]  in_d3, out_d3;
  logic [CW3-1:0] occ3;
  logic           rst2, flush2, in_v2, in_rdy2, out_v2, out_r2;
  logic [W2-1:0]  in_d2, out_d2;
  logic [CW2-1:0] occ2;
  logic           rst1, flush1, in_v1, in_rdy1, out_v1, out_r1;
  logic [W1-1:0]  in_d1, out_d1;
  logic [CW1-1:0] occ1;

  pipe_lanes_elastic #(.LANES(16), .D_WIDTH(192), .DEPTH(3), .CLR_DATA(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst3), .flush(flush3), .in_valid(in_v3), .in_ready(in_rdy3),
    .in_data(in_d3), .out_valid(out_v3), .out_ready(out_r3), .out_data(out_d3),
    .occupancy(occ3));

  pipe_lanes_elastic #(.LANES(4), .D_WIDTH(16), .DEPTH(2), .CLR_DATA(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst2), .flush(flush2), .in_valid(in_v2), .in_ready(in_rdy2),
    .in_data(in_d2), .out_valid(out_v2), .out_ready(out_r2), .out_data(out_d2),
    .occupancy(occ2));

  pipe_lanes_elastic #(.LANES(2), .D_WIDTH(8), .DEPTH(1), .CLR_DATA(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst1), .flush(flush1), .in_valid(in_v1), .in_ready(in_rdy1),
    .in_data(in_d1), .out_valid(out_v1), .out_ready(out_r1), .out_data(out_d1),
    .occupancy(occ1));

  int n_checks = 0;
  int n_pass   = 0;
  int id_in2, id_out2, occ_m2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_data(input string tag, input logic [W3-1:0] obs, input logic [W3-1:0] exp);
    int c;
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      c = 0;
      for (int i = W3 / 64 - 1; i >= 0; i--) if (obs[i*64 +: 64] !== exp[i*64 +: 64]) c = i;
      $error("FAIL %s: observed chunk%0d=%h expected %h", tag, c, obs[c*64 +: 64], exp[c*64 +: 64]);
    end
  endtask

  // Lane k of beat id carries {id, k}.
  function automatic logic [W3-1:0] beat3(input int id);
    logic [W3-1:0] b = '0;
    for (int k = 0; k < 16; k++) b[lane_lsb(k, 192) +: 192] = {168'd0, id[15:0], k[7:0]};
    return b;
  endfunction

  function automatic logic [W2-1:0] beat2(input int id);
    logic [W2-1:0] b = '0;
    for (int k = 0; k < 4; k++) b[lane_lsb(k, 16) +: 16] = {id[11:0], k[3:0]};
    return b;
  endfunction

  task automatic drive2(input logic v, input logic r);
    in_v2  = v;
    out_r2 = r;
    in_d2  = v ? beat2(id_in2) : 'x;
  endtask

  // One dut2 cycle: sample at the falling edge, score transfers, step past the rising edge.
  task automatic tick2();
    @(negedge clk);
    check("occ2_model", 64'(occ2), 64'(occ_m2));
    check("occ2_bound", 64'(occ2 <= 4), 64'd1);
    if (out_v2 && out_r2) begin
      check_data("data2", W3'(out_d2), W3'(beat2(id_out2)));
      id_out2++;
      occ_m2--;
    end
    if (in_v2 && in_rdy2) begin
      id_in2++;
      occ_m2++;
    end
    @(posedge clk);
    #1;
  endtask

  int acc3 [1:100];
  int id_in, id_out, cyc, tgt, guard;

  initial begin
    rst3 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;
    flush3 = 1'b0; flush2 = 1'b0; flush1 = 1'b0;
    in_v2 = 1'b0; in_v1 = 1'b0; out_r3 = 1'b0; out_r2 = 1'b0; out_r1 = 1'b0;
    in_d2 = 'x; in_d1 = 'x;
    // Reset must win over a concurrent flush and a valid input beat.
    in_v3 = 1'b1; in_d3 = beat3(99); flush3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
    flush3 = 1'b0; in_v3 = 1'b0; in_d3 = 'x;
    @(negedge clk);
    check("rst_out_valid", 64'(out_v3), 64'd0);
    check("rst_in_ready", 64'(in_rdy3), 64'd1);
    check("rst_occ", 64'(occ3), 64'd0);
    check_data("rst_out_data", out_d3, '0);

    // Streaming through the wide DEPTH=3 pipe.
    @(posedge clk);
    #1;
    out_r3 = 1'b1; id_in = 1; id_out = 1; cyc = 0;
    in_v3 = 1'b1; in_d3 = beat3(1);
    while (id_out <= 100 && cyc < 400) begin
      @(negedge clk);
      if (in_v3 && cyc >= 3) check("stream_occ", 64'(occ3), 64'd3);
      if (out_v3 && out_r3) begin
        check_data("stream_data", out_d3, beat3(id_out));
        check("stream_lat", 64'(cyc - acc3[id_out]), 64'd3);
        id_out++;
      end
      if (in_v3 && in_rdy3) begin
        acc3[id_in] = cyc;
        id_in++;
      end
      @(posedge clk);
      #1;
      cyc++;
      in_v3 = (id_in <= 100);
      in_d3 = in_v3 ? beat3(id_in) : 'x;
    end
    check("stream_done", 64'(id_out), 64'd101);
    check("stream_rate", 64'(acc3[100]), 64'd99);
    @(negedge clk);
    check("stream_empty", 64'(out_v3), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure on DEPTH=2: capacity is exactly four beats.
    id_in2 = 1; id_out2 = 1; occ_m2 = 0;
    repeat (8) begin
      drive2(1'b1, 1'b0);
      tick2();
    end
    check("bp_accepted", 64'(id_in2 - 1), 64'd4);
    check("bp_in_ready", 64'(in_rdy2), 64'd0);
    check("bp_occ", 64'(occ2), 64'd4);
    check("bp_out_valid", 64'(out_v2), 64'd1);
    check_data("bp_hold", W3'(out_d2), W3'(beat2(1)));
    repeat (10) begin
      drive2(1'b1, 1'b1);
      check("bp_nogap", 64'(out_v2), 64'd1);
      tick2();
    end
    check("bp_drained", 64'(id_out2), 64'd11);

    // Random stalls on both sides, 10000 beats scored in order.
    tgt = id_out2 + 10000;
    guard = 0;
    while (id_out2 < tgt && guard < 60000) begin
      drive2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick2();
      guard++;
    end
    check("rand_done", 64'(id_out2 >= tgt), 64'd1);

    // Flush with three beats held and a valid beat offered in the flush cycle.
    for (int g = 0; g < 20 && occ_m2 != 0; g++) begin
      drive2(1'b0, 1'b1);
      tick2();
    end
    check("fl_drain_occ", 64'(occ2), 64'd0);
    repeat (3) begin
      drive2(1'b1, 1'b0);
      tick2();
    end
    check("fl_pre_occ", 64'(occ2), 64'd3);
    flush2 = 1'b1;
    drive2(1'b1, 1'b0);
    @(negedge clk);
    check("fl_offer_ready", 64'(in_rdy2), 64'd1);
    @(posedge clk);
    #1;
    flush2 = 1'b0;
    occ_m2 = 0;
    id_in2++;
    id_out2 = id_in2;
    drive2(1'b0, 1'b0);
    check("fl_occ", 64'(occ2), 64'd0);
    check("fl_out_valid", 64'(out_v2), 64'd0);
    check("fl_in_ready", 64'(in_rdy2), 64'd1);
    check_data("fl_out_data", W3'(out_d2), '0);
    repeat (5) begin
      drive2(1'b1, 1'b1);
      tick2();
    end
    repeat (4) begin
      drive2(1'b0, 1'b1);
      tick2();
    end
    check("fl_all_out", 64'(id_out2), 64'(id_in2));

    // Mid-stream reset on DEPTH=1 without data clear.
    out_r1 = 1'b0;
    in_v1 = 1'b1; in_d1 = 16'hA1B1;
    @(posedge clk);
    #1;
    in_d1 = 16'hA2B2;
    @(posedge clk);
    #1;
    in_v1 = 1'b0; in_d1 = 'x;
    check("mr_full_occ", 64'(occ1), 64'd2);
    check("mr_full_ready", 64'(in_rdy1), 64'd0);
    check("mr_full_data", 64'(out_d1), 64'hA1B1);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    check("mr_out_valid", 64'(out_v1), 64'd0);
    check("mr_occ", 64'(occ1), 64'd0);
    check("mr_in_ready", 64'(in_rdy1), 64'd1);
    check("mr_data_kept", 64'(out_d1), 64'hA1B1);
    in_v1 = 1'b1; in_d1 = 16'h5C3D; out_r1 = 1'b1;
    @(posedge clk);
    #1;
    in_v1 = 1'b0; in_d1 = 'x;
    check("mr_new_valid", 64'(out_v1), 64'd1);
    check("mr_new_data", 64'(out_d1), 64'h5C3D);
    check("mr_new_occ", 64'(occ1), 64'd1);
    @(posedge clk);
    #1;
    check("mr_no_stale", 64'(out_v1), 64'd0);
    check("mr_end_occ", 64'(occ1), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_lanes_elastic.md
Name: pipe_lanes_elastic

Overview:
- Parametrised multi-lane pipeline register, replacing fixed 16-lane/192-bit free-running pipe registers between FFT butterfly and twiddle stages.
- Adds configurable lane count, data width and stage depth, plus a valid/ready handshake with backpressure, synchronous flush and an occupancy counter.
- Each stage is a registered-ready skid slice, so long pipes close timing without a combinational ready chain.

Parameters:
- LANES, 16, number of parallel data lanes (≥1).
- D_WIDTH, 192, bits per lane (≥1).
- DEPTH, 1, number of skid-slice stages (≥1).
- CLR_DATA, 1, 1 = reset/flush also zeroes data registers; 0 = only valid state is cleared.
- CNT_W, $clog2(2*DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all stored beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat; registered.
- in_data  in  LANES*D_WIDTH  lane k at bits [k*D_WIDTH +: D_WIDTH].
- out_valid  out  1  downstream beat valid; registered.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*D_WIDTH  same lane packing; registered.
- occupancy  out  CNT_W  beats currently held, 0..2*DEPTH.

Behaviour:
- Beat transfer: in-side on in_valid&&in_ready; out-side on out_valid&&out_ready. Lanes always travel together as one beat.
- Reset (rst_n=0 at clk edge):
  - out_valid=0, in_ready=1, occupancy=0.
  - out_data and all internal data = 0 if CLR_DATA=1, else unchanged.
  - Reset takes priority over flush and handshake.
  - Reset mid-stream discards all held beats; no beat emerges afterwards.
- Flush (rst_n=1, flush=1): same register effect as reset. An in-side transfer in the flush cycle is dropped. in_ready=1 on the next cycle.
- Each slice has states EMPTY (no beat), ONE (main reg valid), TWO (main + skid valid).
  - slice in_ready = (state != TWO), registered.
  - EMPTY: accept → ONE.
  - ONE: accept & no drain → TWO (beat into skid); drain & no accept → EMPTY; accept & drain → ONE (main loads new beat).
  - TWO: drain → ONE (skid moves to main); no accept possible.
  - out_valid = state != EMPTY; out_data = main reg.
- Slices are chained: slice i output feeds slice i+1 input; ready flows back.
- Latency: with out_ready=1 and no stalls, a beat accepted at edge t appears on out_data/out_valid after edge t+DEPTH-1, i.e. DEPTH cycles in-to-out. Throughput 1 beat/cycle.
- Capacity: 2*DEPTH beats.
  - Under sustained out_ready=0, in_ready drops once 2*DEPTH beats are held, or earlier once the first slice is full.
  - No beat is lost or duplicated; order is preserved.
- occupancy: +1 on in-transfer, −1 on out-transfer, unchanged on both or neither. Registered. Never exceeds 2*DEPTH or goes below 0.
- Data is held stable while out_valid=1 and out_ready=0.
- in_valid=0 with in_ready=1 causes no state change.
- X on in_data is never captured unless in_valid=1.

Decomposition:
- Package pipe_pkg:
  - lane slice function/macro for bus packing.
  - CNT_W derivation function.
  - slice state enum {EMPTY, ONE, TWO}.
- Sub-module pipe_skid_slice (params: W = LANES*D_WIDTH, CLR_DATA), instantiated DEPTH times in a generate loop.
- The top holds only the chain wiring and the occupancy counter.

Test Plan:
- Reset: DEPTH=3, drive rst_n=0 for 2 cycles → out_valid=0, in_ready=1, occupancy=0, out_data=0 (CLR_DATA=1).
- Streaming: LANES=16, D_WIDTH=192, DEPTH=3, out_ready=1, send beats with lane k = {beat_id, k}, ids 1..100 → ids emerge in order 3 cycles after acceptance, one per cycle, occupancy steady at 3.
- Backpressure: DEPTH=2, out_ready=0, in_valid=1 continuously → exactly 4 beats accepted, in_ready=0, occupancy=4. Raise out_ready → beats 1..4 then 5.. out in order, no gaps or duplicates.
- Random stall: 10,000 beats, in_valid and out_ready random at 50% → scoreboard matches exactly; occupancy always equals the reference model count and stays ≤ 2*DEPTH.
- Flush: occupancy=3, assert flush with in_valid=1 → next cycle occupancy=0, out_valid=0, the flush-cycle beat never appears.
- Mid-stream reset with CLR_DATA=0: DEPTH=1, hold 2 beats, pulse rst_n=0 → out_valid=0, occupancy=0, out_data retains its last value; the next beat sent emerges correctly.
